// File: rtl/ifetch.sv
// Instruction fetch stage: one-outstanding icache request, predictor-driven
// next PC, redirect handling and a small instruction queue toward decode.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int IQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        oIC_Req,
  output logic [31:0] oIC_Addr,
  input  logic        iIC_En,
  input  logic [31:0] iIC_Ins,
  output logic [31:0] oBP_Pc,
  input  logic        iBP_En,
  input  logic [31:0] iBP_Pcn,
  input  logic        iFlush,
  input  logic [31:0] iFlush_Pc,
  output logic        oDec_Valid,
  output logic [31:0] oDec_Ins,
  output logic [31:0] oDec_Pc,
  input  logic        iDec_Rdy
);

  localparam int PW = $clog2(IQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(IQ_DEPTH);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_NEXT
  } state_t;

  state_t state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] rpc, rpc_n;
  logic drop, drop_n;
  logic redir, redir_n;
  logic enq, deq;

  logic [CW-1:0] count;
  logic [PW-1:0] head, tail;
  logic [31:0] q_pc [IQ_DEPTH];
  logic [31:0] q_ins [IQ_DEPTH];

  assign oIC_Req    = (state == S_WAIT) && !rst;
  assign oIC_Addr   = pc;
  assign oBP_Pc     = pc;
  assign oDec_Valid = (count != '0) && !rst;
  assign oDec_Ins   = q_ins[head];
  assign oDec_Pc    = q_pc[head];
  assign deq        = (count != '0) && iDec_Rdy;

  // FSM state and fetch-control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
      pc    <= RESET_PC;
      rpc   <= '0;
      drop  <= 1'b0;
      redir <= 1'b0;
    end else if (en) begin
      state <= state_n;
      pc    <= pc_n;
      rpc   <= rpc_n;
      drop  <= drop_n;
      redir <= redir_n;
    end
  end

  // Next-state, redirect bookkeeping and enqueue decision
  always_comb begin
    state_n = state;
    pc_n    = pc;
    rpc_n   = rpc;
    drop_n  = drop;
    redir_n = redir;
    enq     = 1'b0;
    unique case (state)
      S_REQ: begin
        if (iFlush) pc_n = iFlush_Pc;
        if (count < DEPTH_C) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (iIC_En) begin
          state_n = S_NEXT;
          drop_n  = 1'b0;
          enq     = !drop && !iFlush;
          if (iFlush) begin
            redir_n = 1'b1;
            rpc_n   = iFlush_Pc;
          end
        end else if (iFlush) begin
          drop_n  = 1'b1;
          redir_n = 1'b1;
          rpc_n   = iFlush_Pc;
        end
      end
      S_NEXT: begin
        if (iBP_En) begin
          state_n = S_REQ;
          redir_n = 1'b0;
          if (iFlush)
            pc_n = iFlush_Pc;
          else
            pc_n = redir ? rpc : iBP_Pcn;
        end else if (iFlush) begin
          redir_n = 1'b1;
          rpc_n   = iFlush_Pc;
        end
      end
      default: state_n = S_REQ;
    endcase
  end

  // Queue occupancy and pointers; a flush empties everything
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (en) begin
      if (iFlush) begin
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        if (enq) tail <= tail + PW'(1);
        if (deq) head <= head + PW'(1);
        if (enq && !deq)
          count <= count + CW'(1);
        else if (!enq && deq)
          count <= count - CW'(1);
      end
    end
  end

  // Queue storage write at the tail
  always_ff @(posedge clk) begin
    if (!rst && en && enq) begin
      q_pc[tail]  <= pc;
      q_ins[tail] <= iIC_Ins;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: drives icache/predictor/decoder by hand and
// checks decoder output against a scoreboard of accepted fetches.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        oIC_Req;
  logic [31:0] oIC_Addr;
  logic        iIC_En;
  logic [31:0] iIC_Ins;
  logic [31:0] oBP_Pc;
  logic        iBP_En;
  logic [31:0] iBP_Pcn;
  logic        iFlush;
  logic [31:0] iFlush_Pc;
  logic        oDec_Valid;
  logic [31:0] oDec_Ins;
  logic [31:0] oDec_Pc;
  logic        iDec_Rdy;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_pc;
  logic [63:0] sb [$];

  ifetch #(.RESET_PC(32'h0), .IQ_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en),
    .oIC_Req(oIC_Req), .oIC_Addr(oIC_Addr),
    .iIC_En(iIC_En), .iIC_Ins(iIC_Ins),
    .oBP_Pc(oBP_Pc), .iBP_En(iBP_En), .iBP_Pcn(iBP_Pcn),
    .iFlush(iFlush), .iFlush_Pc(iFlush_Pc),
    .oDec_Valid(oDec_Valid), .oDec_Ins(oDec_Ins),
    .oDec_Pc(oDec_Pc), .iDec_Rdy(iDec_Rdy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (oIC_Req !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    chk("req_wait", {31'b0, oIC_Req}, 32'd1);
  endtask

  task automatic pop_chk();
    logic [63:0] e;
    chk("head_valid", {31'b0, oDec_Valid}, 32'd1);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("head_pc", oDec_Pc, e[63:32]);
      chk("head_ins", oDec_Ins, e[31:0]);
    end
  endtask

  task automatic deq_one();
    pop_chk();
    iDec_Rdy = 1'b1;
    step();
    iDec_Rdy = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] ins, input logic [31:0] pcn,
                       input bit dq);
    wait_req();
    chk("ic_addr", oIC_Addr, exp_pc);
    chk("bp_pc", oBP_Pc, exp_pc);
    iIC_En  = 1'b1;
    iIC_Ins = ins;
    if (dq) begin
      pop_chk();
      iDec_Rdy = 1'b1;
    end
    sb.push_back({exp_pc, ins});
    step();
    iIC_En   = 1'b0;
    iDec_Rdy = 1'b0;
    chk("req_in_next", {31'b0, oIC_Req}, 32'd0);
    iBP_En  = 1'b1;
    iBP_Pcn = pcn;
    step();
    iBP_En = 1'b0;
    exp_pc = pcn;
  endtask

  initial begin
    logic [63:0] hd;
    rst = 1'b1; en = 1'b1;
    iIC_En = 1'b0; iIC_Ins = '0;
    iBP_En = 1'b0; iBP_Pcn = '0;
    iFlush = 1'b1; iFlush_Pc = 32'h500;
    iDec_Rdy = 1'b0;
    exp_pc = 32'h0;

    // reset, with a flush held to show reset wins
    step();
    step();
    chk("rst_req", {31'b0, oIC_Req}, 32'd0);
    chk("rst_valid", {31'b0, oDec_Valid}, 32'd0);
    rst = 1'b0;
    iFlush = 1'b0;
    chk("first_cycle_req", {31'b0, oIC_Req}, 32'd0);
    step();
    chk("second_cycle_req", {31'b0, oIC_Req}, 32'd1);
    chk("reset_pc", oIC_Addr, 32'h0);

    // basic sequential fetch 0,4,8
    fetch(32'h00000013, 32'h4, 1'b0);
    fetch(32'h00000013, 32'h8, 1'b0);
    fetch(32'h00000013, 32'hC, 1'b0);
    hd = sb[0];
    chk("q0_pc", oDec_Pc, hd[63:32]);
    chk("q0_ins", oDec_Ins, 32'h00000013);

    // fill the queue and stall
    fetch(32'h00100093, 32'h10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_no_req", {31'b0, oIC_Req}, 32'd0);
    end
    deq_one();
    fetch(32'h00200113, 32'h14, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("refull_no_req", {31'b0, oIC_Req}, 32'd0);
    end

    // drain three, leaving one entry, ending in WAIT
    deq_one();
    deq_one();
    deq_one();

    // flush during WAIT; late response must be dropped
    iFlush = 1'b1; iFlush_Pc = 32'h100;
    step();
    iFlush = 1'b0;
    sb.delete();
    chk("flush_empty", {31'b0, oDec_Valid}, 32'd0);
    chk("flush_req_held", {31'b0, oIC_Req}, 32'd1);
    chk("flush_addr_held", oIC_Addr, 32'h14);
    iIC_En = 1'b1; iIC_Ins = 32'hDEADBEEF;
    step();
    iIC_En = 1'b0;
    chk("late_dropped", {31'b0, oDec_Valid}, 32'd0);
    iBP_En = 1'b1; iBP_Pcn = 32'h18;
    step();
    iBP_En = 1'b0;
    wait_req();
    chk("redirect_addr", oIC_Addr, 32'h100);

    // flush together with predictor response
    iIC_En = 1'b1; iIC_Ins = 32'h00000011;
    step();
    iIC_En = 1'b0;
    chk("enq_after_drop", {31'b0, oDec_Valid}, 32'd1);
    chk("enq_after_drop_pc", oDec_Pc, 32'h100);
    iBP_En = 1'b1; iBP_Pcn = 32'h8;
    iFlush = 1'b1; iFlush_Pc = 32'h200;
    step();
    iBP_En = 1'b0; iFlush = 1'b0;
    chk("flush_bp_empty", {31'b0, oDec_Valid}, 32'd0);
    exp_pc = 32'h200;

    // pointer wrap with simultaneous enqueue/dequeue at count 3
    fetch(32'hA0000000, 32'h204, 1'b0);
    fetch(32'hA0000001, 32'h208, 1'b0);
    fetch(32'hA0000002, 32'h20C, 1'b0);
    fetch(32'hA0000003, 32'h210, 1'b1);
    fetch(32'hA0000004, 32'h214, 1'b1);
    deq_one();
    deq_one();

    // enable low during WAIT with noisy inputs
    chk("pre_stall_req", {31'b0, oIC_Req}, 32'd1);
    en = 1'b0;
    iIC_En = 1'b1; iFlush = 1'b1; iFlush_Pc = 32'h900;
    iDec_Rdy = 1'b1; iBP_En = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_req", {31'b0, oIC_Req}, 32'd1);
      chk("stall_addr", oIC_Addr, 32'h214);
      chk("stall_valid", {31'b0, oDec_Valid}, 32'd1);
      chk("stall_head", oDec_Pc, 32'h210);
    end
    en = 1'b1;
    iIC_En = 1'b0; iFlush = 1'b0;
    iDec_Rdy = 1'b0; iBP_En = 1'b0;
    fetch(32'hA0000005, 32'h218, 1'b0);
    deq_one();
    deq_one();
    chk("final_empty", {31'b0, oDec_Valid}, 32'd0);
    chk("final_sb", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
